// File: rtl/ring4_wave_sched.sv
// Round-robin scheduler driving DATA/NULL wavefronts onto one four-rail NCL channel,
// paced by the synchronized downstream completion signal.
module ring4_wave_sched #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  init,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     req_val,
  input  logic                  halt,
  output logic [NREQ-1:0]       grant,
  output logic [3:0]            rails,
  input  logic                  comp,
  output logic                  done,
  output logic                  err,
  output logic [CNT_W-1:0]      wave_cnt
);

  localparam int unsigned PTR_W = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int unsigned SUM_W = PTR_W + 1;
  localparam int unsigned TMR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_NULL = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [NREQ-1:0]        grant_q, grant_d;
  logic [3:0]             rails_q, rails_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   comp_s;
  logic                   win_vld;
  logic [PTR_W-1:0]       win_idx;
  logic [1:0]             sel_val;
  logic                   start_c;
  logic                   tmo_c;

  // Completion synchronizer: shift comp through SYNC_STAGES flops.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], comp};
  end

  assign comp_s  = sync_q[SYNC_STAGES-1];
  assign tmo_c   = (timer_q == TMR_W'(TIMEOUT - 1));
  assign start_c = (state_q == ST_IDLE) && !halt && !comp_s && win_vld;

  // Round-robin winner: first asserted req at or after the pointer, wrapping.
  always_comb begin
    logic [SUM_W-1:0] sum;
    logic [PTR_W-1:0] idx;
    win_vld = 1'b0;
    win_idx = '0;
    sum     = '0;
    idx     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      sum = {1'b0, ptr_q} + SUM_W'(i);
      if (sum >= SUM_W'(NREQ)) sum = sum - SUM_W'(NREQ);
      idx = sum[PTR_W-1:0];
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
    end
  end

  // Winner's 2-bit value, sampled only when the grant is taken.
  always_comb begin
    sel_val = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_idx == PTR_W'(i)) sel_val = req_val[2*i +: 2];
    end
  end

  // Next-state and phase timer; a phase exit takes priority over a timeout.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d = ST_DATA;
          timer_d = '0;
        end
      end
      ST_DATA: begin
        if (comp_s) begin
          state_d = ST_NULL;
          timer_d = '0;
        end else if (tmo_c) begin
          state_d = ST_ERR;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_NULL: begin
        if (!comp_s) begin
          state_d = ST_IDLE;
        end else if (tmo_c) begin
          state_d = ST_ERR;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_ERR;
      end
    endcase
  end

  // Registered output values for the next cycle.
  always_comb begin
    grant_d = '0;
    rails_d = rails_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        rails_d = '0;
        if (start_c) begin
          grant_d = NREQ'(1) << win_idx;
          rails_d = 4'b0001 << sel_val;
          ptr_d   = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end
      end
      ST_DATA: begin
        if (comp_s) begin
          rails_d = '0;
        end else if (tmo_c) begin
          rails_d = '0;
          err_d   = 1'b1;
        end
      end
      ST_NULL: begin
        rails_d = '0;
        if (!comp_s) begin
          done_d = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
        end else if (tmo_c) begin
          err_d = 1'b1;
        end
      end
      ST_ERR: begin
        rails_d = '0;
        err_d   = 1'b1;
      end
      default: begin
        rails_d = '0;
        err_d   = 1'b1;
      end
    endcase
  end

  // State and output registers; init clears everything, including rails, without a clock.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q <= ST_IDLE;
      sync_q  <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
      grant_q <= '0;
      rails_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      grant_q <= grant_d;
      rails_q <= rails_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant    = grant_q;
  assign rails    = rails_q;
  assign done     = done_q;
  assign err      = err_q;
  assign wave_cnt = cnt_q;

endmodule

// File: tb/tb_ring4_wave_sched.sv
// Directed bench for ring4_wave_sched: main instance (TIMEOUT=8) plus a CNT_W=2 instance for wrap.
module tb_ring4_wave_sched;

  logic        clk;
  logic        init;
  logic [3:0]  req;
  logic [7:0]  req_val;
  logic        halt;
  logic [3:0]  grant;
  logic [3:0]  rails;
  logic        comp;
  logic        done;
  logic        err;
  logic [15:0] wave_cnt;

  logic        auto_en;
  logic        comp_man;
  logic        comp_auto;
  int          acnt;

  logic [3:0]  req_w;
  logic [7:0]  req_val_w;
  logic        halt_w;
  logic [3:0]  grant_w;
  logic [3:0]  rails_w;
  logic        comp_w;
  logic        done_w;
  logic        err_w;
  logic [1:0]  wave_cnt_w;

  int n_vec;
  int n_err;

  ring4_wave_sched #(.NREQ(4), .SYNC_STAGES(2), .TIMEOUT(8), .CNT_W(16)) u_dut (
    .clk(clk), .init(init), .req(req), .req_val(req_val), .halt(halt),
    .grant(grant), .rails(rails), .comp(comp), .done(done), .err(err),
    .wave_cnt(wave_cnt)
  );

  ring4_wave_sched #(.NREQ(4), .SYNC_STAGES(2), .TIMEOUT(255), .CNT_W(2)) u_w (
    .clk(clk), .init(init), .req(req_w), .req_val(req_val_w), .halt(halt_w),
    .grant(grant_w), .rails(rails_w), .comp(comp_w), .done(done_w), .err(err_w),
    .wave_cnt(wave_cnt_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign comp = auto_en ? comp_auto : comp_man;

  // Downstream model: comp rises 3 cycles after DATA appears, falls 3 cycles after NULL.
  always @(negedge clk) begin
    if (init) begin
      comp_auto = 1'b0;
      acnt      = 0;
    end else if ((rails != 4'b0000) && !comp_auto) begin
      acnt = acnt + 1;
      if (acnt == 3) begin
        comp_auto = 1'b1;
        acnt      = 0;
      end
    end else if ((rails == 4'b0000) && comp_auto) begin
      acnt = acnt + 1;
      if (acnt == 3) begin
        comp_auto = 1'b0;
        acnt      = 0;
      end
    end else begin
      acnt = 0;
    end
  end

  // Fast downstream model for the wrap instance.
  always @(negedge clk) begin
    comp_w = init ? 1'b0 : (rails_w != 4'b0000);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    do begin tick(); n++; end while (grant == 4'b0000 && n < 40);
    chk(tag, 32'(grant != 4'b0000), 32'd1);
  endtask

  task automatic wait_rails0(input string tag);
    int n = 0;
    do begin tick(); n++; end while (rails != 4'b0000 && n < 40);
    chk(tag, 32'(rails == 4'b0000), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin tick(); n++; end while (!done && n < 40);
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_done_w(input string tag);
    int n = 0;
    do begin tick(); n++; end while (!done_w && n < 40);
    chk(tag, 32'(done_w), 32'd1);
  endtask

  logic [3:0] rr_exp [5];
  logic       saw_grant;

  initial begin
    n_vec = 0;
    n_err = 0;
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    init = 1'b1; req = '0; req_val = '0; halt = 1'b0;
    auto_en = 1'b1; comp_man = 1'b0;
    req_w = '0; req_val_w = 8'h00; halt_w = 1'b0;

    // Reset state
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_rails", 32'(rails), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_cnt", 32'(wave_cnt), 32'h0);
    tick(); tick();
    init = 1'b0;
    tick();

    // 1: single requester, value 2
    req = 4'b0001; req_val = 8'h02;
    wait_grant("t1_wait_grant");
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_rails", 32'(rails), 32'h4);
    req = 4'b0000;
    tick();
    chk("t1_grant_pulse", 32'(grant), 32'h0);
    while (!comp) tick();
    chk("t1_rails_at_comp", 32'(rails), 32'h4);
    tick();
    chk("t1_rails_sync1", 32'(rails), 32'h4);
    tick();
    chk("t1_rails_null", 32'(rails), 32'h0);
    wait_done("t1_done");
    chk("t1_cnt", 32'(wave_cnt), 32'd1);
    tick();
    chk("t1_done_pulse", 32'(done), 32'h0);

    // 2: round-robin from pointer 0, values 0..3
    init = 1'b1; #2; init = 1'b0;
    req = 4'b1111; req_val = 8'hE4;
    for (int k = 0; k < 5; k++) begin
      wait_grant("t2_wait_grant");
      chk("t2_grant", 32'(grant), 32'(rr_exp[k]));
      chk("t2_rails", 32'(rails), 32'(rr_exp[k]));
      if (k == 4) req = 4'b0000;
      wait_rails0("t2_null");
      wait_done("t2_done");
    end
    chk("t2_cnt", 32'(wave_cnt), 32'd5);

    // 3: stale completion blocks grants until comp falls
    auto_en = 1'b0; comp_man = 1'b1;
    tick(); tick(); tick();
    req = 4'b0001; req_val = 8'h01;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_no_grant", 32'(grant), 32'h0);
      chk("t3_no_rails", 32'(rails), 32'h0);
    end
    comp_man = 1'b0;
    tick();
    chk("t3_grant_s1", 32'(grant), 32'h0);
    tick();
    chk("t3_grant_s2", 32'(grant), 32'h0);
    tick();
    chk("t3_grant", 32'(grant), 32'h1);
    chk("t3_rails", 32'(rails), 32'h2);
    req = 4'b0000;
    auto_en = 1'b1;
    wait_done("t3_done");
    chk("t3_cnt", 32'(wave_cnt), 32'd6);

    // 4: DATA timeout with comp stuck low
    auto_en = 1'b0; comp_man = 1'b0;
    req = 4'b0001; req_val = 8'h03;
    wait_grant("t4_wait_grant");
    chk("t4_rails", 32'(rails), 32'h8);
    req = 4'b0000;
    repeat (7) tick();
    chk("t4_rails_c7", 32'(rails), 32'h8);
    chk("t4_err_c7", 32'(err), 32'h0);
    tick();
    chk("t4_rails_c8", 32'(rails), 32'h0);
    chk("t4_err_c8", 32'(err), 32'h1);
    req = 4'b0001;
    saw_grant = 1'b0;
    repeat (10) begin
      tick();
      if (grant != 4'b0000) saw_grant = 1'b1;
    end
    chk("t4_no_grant_err", 32'(saw_grant), 32'h0);
    chk("t4_err_sticky", 32'(err), 32'h1);
    chk("t4_cnt_frozen", 32'(wave_cnt), 32'd6);
    req = 4'b0000;
    init = 1'b1; #2;
    chk("t4_init_err", 32'(err), 32'h0);
    chk("t4_init_cnt", 32'(wave_cnt), 32'h0);
    init = 1'b0;
    auto_en = 1'b1;
    tick();

    // 5: reset mid-DATA drops rails without a clock
    req = 4'b1000; req_val = 8'hC0;
    wait_grant("t5_wait_grant");
    chk("t5_grant", 32'(grant), 32'h8);
    chk("t5_rails", 32'(rails), 32'h8);
    req = 4'b0000;
    tick();
    chk("t5_rails_hold", 32'(rails), 32'h8);
    init = 1'b1; #1;
    chk("t5_rails_async", 32'(rails), 32'h0);
    init = 1'b0;
    req = 4'b1111; req_val = 8'hE4;
    wait_grant("t5_wait_grant2");
    chk("t5_grant_r0", 32'(grant), 32'h1);
    chk("t5_rails_r0", 32'(rails), 32'h1);
    req = 4'b0000;
    wait_done("t5_done");

    // 6a: halt during DATA lets the wavefront finish, then blocks grants
    req = 4'b0001; req_val = 8'h02;
    wait_grant("t6_wait_grant");
    chk("t6_rails", 32'(rails), 32'h4);
    halt = 1'b1;
    wait_done("t6_done");
    chk("t6_cnt", 32'(wave_cnt), 32'd2);
    saw_grant = 1'b0;
    repeat (8) begin
      tick();
      if (grant != 4'b0000) saw_grant = 1'b1;
    end
    chk("t6_no_grant_halt", 32'(saw_grant), 32'h0);
    halt = 1'b0;
    wait_grant("t6_wait_grant2");
    chk("t6_grant_resume", 32'(grant), 32'h1);
    req = 4'b0000;
    wait_done("t6_done2");

    // 6b: 2-bit counter wraps 1,2,3,0
    req_w = 4'b0001;
    for (int k = 1; k <= 4; k++) begin
      wait_done_w("t6_wrap_done");
      chk("t6_wrap_cnt", 32'(wave_cnt_w), 32'(k % 4));
    end
    req_w = 4'b0000;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ring4_wave_sched.md
Name: ring4_wave_sched

Overview:
- Clocked scheduler that shares one four-rail (1-of-4) NCL channel between NREQ synchronous requesters.
- Takes 2-bit values from requesters in round-robin order and drives each value as a DATA wavefront, then a NULL wavefront, on `rails`.
- Paces both wavefronts from the downstream completion signal `comp`. `comp` high means downstream holds DATA and requests NULL; `comp` low means it requests DATA.
- Sits at the clocked/NCL boundary: it feeds a four-rail pipeline ring entry and watches its completion output.

Parameters:
- NREQ, 4, number of requesters (2..8).
- SYNC_STAGES, 2, flop stages on `comp` (≥2).
- TIMEOUT, 255, maximum cycles allowed in the DATA or NULL phase before error (1..65535).
- CNT_W, 16, width of the completed-wavefront counter.

Ports:
- clk, input, 1, single clock.
- init, input, 1, reset: asynchronous, active-high.
- req, input, NREQ, per-requester valid; level, held until granted.
- req_val, input, 2*NREQ, 2-bit value per requester; requester i uses bits [2i+1:2i].
- halt, input, 1, when high no new grant is issued; a wavefront already in flight completes.
- grant, output, NREQ, one-hot, one-cycle pulse; the granted requester's value is consumed that cycle.
- rails, output, 4, four-rail channel; one-hot = DATA, all-zero = NULL.
- comp, input, 1, asynchronous completion from the NCL ring.
- done, output, 1, one-cycle pulse when the NULL phase completes.
- err, output, 1, sticky timeout flag.
- wave_cnt, output, CNT_W, count of completed DATA+NULL cycles.

Behaviour:
- Reset (init=1, async): `grant`=0, `rails`=0, `done`=0, `err`=0, `wave_cnt`=0. Synchronizer flops=0, state=IDLE, round-robin pointer=0, timer=0.
- Reset mid-wavefront: `rails` drops to 0 immediately, with no clock needed.
- `comp_s` is `comp` after SYNC_STAGES flops. All decisions use only `comp_s`.
- States: IDLE, DATA, NULL, ERR. All outputs are registered.
- IDLE:
  - A grant is issued only when `halt`=0, `comp_s`=0 and at least one `req` bit is high.
  - Winner = first asserted `req` at or after the pointer, with wrap-around.
  - Same edge: `grant[winner]`=1 for one cycle; `rails` <= one-hot of `req_val[winner]` (0→0001, 1→0010, 2→0100, 3→1000); pointer <= winner+1 mod NREQ; timer cleared; go to DATA.
  - So `rails` becomes valid on the same edge that `grant` pulses.
  - If `comp_s`=1 in IDLE (stale DATA downstream), no grant is issued and the block waits.
- DATA:
  - `rails` is held stable.
  - When `comp_s`=1: `rails` <= 0, timer cleared, go to NULL.
- NULL:
  - `rails`=0.
  - When `comp_s`=0: `done` pulses for one cycle, `wave_cnt` += 1 (wraps modulo 2^CNT_W), go to IDLE.
  - The next grant comes no earlier than the following cycle, so IDLE lasts at least 1 cycle between wavefronts.
- Timer:
  - Increments each cycle in DATA and NULL.
  - If it reaches TIMEOUT before the phase exit condition: `rails` <= 0, `err` <= 1, go to ERR.
  - A timeout and a phase exit in the same cycle: the phase exit wins.
- ERR:
  - Absorbing; only `init` leaves it.
  - No grants, `rails`=0, `done`=0, `err` held at 1, `wave_cnt` frozen.
- `halt`:
  - Sampled only in IDLE.
  - Asserting it during DATA or NULL does not disturb the in-flight wavefront.
- A requester that drops `req` before grant is simply skipped. `req_val` is sampled only on the grant edge.
- Never more than one `grant` bit high, and never more than one `rails` bit high.

Test Plan:
1. Single requester: `req`=0001, `req_val[1:0]`=2; model `comp` rises 3 cycles after `rails` goes high, falls 3 cycles after NULL.
   Required: `grant`=0001 for 1 cycle; `rails`=0100 on that same edge; `rails`=0000 SYNC_STAGES+1 cycles after `comp` rises; `done` pulse; `wave_cnt`=1.
2. Round-robin, all 4 requesting continuously with values 0,1,2,3.
   Required: grant order 0001,0010,0100,1000,0001; rails sequence 0001,0010,0100,1000, each followed by NULL; `wave_cnt`=5.
3. Stale completion: hold `comp`=1 with `req`=0001 in IDLE.
   Required: no grant and `rails`=0 until `comp` falls; grant is issued SYNC_STAGES+1 cycles after `comp` falls.
4. Timeout, TIMEOUT=8: `comp` never rises after DATA.
   Required: after 8 cycles `rails`=0 and `err`=1; further `req` produces no `grant`; `init` clears `err` and `wave_cnt`.
5. Reset mid-DATA: assert `init` between clock edges while `rails`=1000.
   Required: `rails`=0000 before the next edge; after release, first grant goes to requester 0.
6. Halt, plus counter wrap with CNT_W=2: assert `halt` during DATA.
   Required: the wavefront completes with a `done` pulse; no new grant while `halt`=1.
   Then run 4 wavefronts: `wave_cnt` goes 1,2,3,0.
